// File: rtl/stim_pkg.sv
// Shared types and constants for the biphasic stimulus sequencer.
// The state enum is the sequencer's pulse timeline in order.
package stim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REST,
    LEAD,
    PH1,
    IPD,
    PH2,
    LAG
  } stim_state_t;

  localparam stim_state_t RESET_STATE = IDLE;
  localparam logic        CTRL_OFF    = 1'b0;

endpackage

// File: rtl/stim_dur_timer.sv
// Loadable down-counter shared by every timed sequencer state.
// A load of D makes the state last max(D,1) cycles, including the load cycle.
module stim_dur_timer #(
  parameter int TW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] dur,
  output logic          expired
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (dur == '0) ? '0 : dur - 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/stim_sequencer_v3.sv
// Clocked charge-balanced biphasic pulse-train sequencer driving EN_ST, MAG_ST
// and the HS/LS channel selects, with ramp, cathode sweep and pulse limit.
module stim_sequencer_v3
  import stim_pkg::*;
#(
  parameter int              TW        = 16,
  parameter int              MAG_W     = 5,
  parameter int              CH_W      = 4,
  parameter int              CNT_W     = 8,
  parameter logic [CH_W-1:0] SWEEP_MIN = 4'd2,
  parameter logic [CH_W-1:0] SWEEP_MAX = 4'd8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic [TW-1:0]    REST_CYC,
  input  logic [TW-1:0]    EXT_CYC,
  input  logic [TW-1:0]    PH1_CYC,
  input  logic [TW-1:0]    IPD_CYC,
  input  logic [TW-1:0]    PH2_CYC,
  input  logic [MAG_W-1:0] MAG_CFG,
  input  logic             RAMP,
  input  logic             SWEEP,
  input  logic             CAT_FIRST,
  input  logic [CH_W-1:0]  CH_ANO,
  input  logic [CH_W-1:0]  CH_CAT,
  input  logic [CNT_W-1:0] N_PULSES,
  output logic             EN_ST,
  output logic [MAG_W-1:0] MAG_ST,
  output logic [CH_W-1:0]  ChSel_HS,
  output logic [CH_W-1:0]  ChSel_LS,
  output logic             BUSY,
  output logic             DONE
);

  stim_state_t      state_q;

  logic [TW-1:0]    rest_l;
  logic [TW-1:0]    ext_l;
  logic [TW-1:0]    ph1_l;
  logic [TW-1:0]    ipd_l;
  logic [TW-1:0]    ph2_l;
  logic [MAG_W-1:0] mag_cfg_l;
  logic             ramp_l;
  logic             sweep_l;
  logic             cat_first_l;
  logic [CH_W-1:0]  ano_l;
  logic [CNT_W-1:0] n_pulses_l;

  logic [CH_W-1:0]  cat_q;
  logic [CNT_W-1:0] pulse_cnt;
  logic             stop_req;

  logic             tmr_load;
  logic [TW-1:0]    tmr_dur;
  logic             tmr_exp;

  logic [CNT_W-1:0] cnt_next;
  logic [MAG_W-1:0] mag_next;
  logic [CH_W-1:0]  cat_next;
  logic             stop_now;
  logic             last_pulse;
  logic [CH_W-1:0]  ph1_hs;
  logic [CH_W-1:0]  ph1_ls;

  // One sweep step: increment, wrapping past SWEEP_MAX back to SWEEP_MIN.
  function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] c);
    logic [CH_W:0] s;
    s = {1'b0, c} + (CH_W+1)'(1);
    if (s > {1'b0, SWEEP_MAX}) begin
      s = {1'b0, SWEEP_MIN};
    end
    return s[CH_W-1:0];
  endfunction

  function automatic logic [CH_W-1:0] sweep_step(input logic [CH_W-1:0] c,
                                                 input logic [CH_W-1:0] ano);
    logic [CH_W-1:0] n;
    n = wrap_inc(c);
    if (n == ano) begin
      n = wrap_inc(n);
    end
    return n;
  endfunction

  stim_dur_timer #(
    .TW(TW)
  ) u_timer (
    .clock  (CLK),
    .reset  (RST),
    .load   (tmr_load),
    .dur    (tmr_dur),
    .expired(tmr_exp)
  );

  // The timer is reloaded on every state exit with the duration of the state being entered.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dur  = '0;
    case (state_q)
      IDLE: begin tmr_load = START;   tmr_dur = REST_CYC; end
      REST: begin tmr_load = tmr_exp; tmr_dur = ext_l;    end
      LEAD: begin tmr_load = tmr_exp; tmr_dur = ph1_l;    end
      PH1:  begin tmr_load = tmr_exp; tmr_dur = ipd_l;    end
      IPD:  begin tmr_load = tmr_exp; tmr_dur = ph2_l;    end
      PH2:  begin tmr_load = tmr_exp; tmr_dur = ext_l;    end
      LAG:  begin tmr_load = tmr_exp; tmr_dur = rest_l;   end
      default: begin tmr_load = 1'b0; tmr_dur = '0;       end
    endcase
  end

  assign cnt_next   = pulse_cnt + 1'b1;
  assign mag_next   = (ramp_l && (MAG_ST < mag_cfg_l)) ? MAG_ST + 1'b1 : MAG_ST;
  assign cat_next   = sweep_l ? sweep_step(cat_q, ano_l) : cat_q;
  assign stop_now   = stop_req | STOP;
  assign last_pulse = stop_now | ((n_pulses_l != '0) && (cnt_next == n_pulses_l));
  assign ph1_hs     = cat_first_l ? cat_q : ano_l;
  assign ph1_ls     = cat_first_l ? ano_l : cat_q;

  // Sequencer FSM; every output is a register updated on the state transition that needs it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RESET_STATE;
      EN_ST       <= CTRL_OFF;
      MAG_ST      <= '0;
      ChSel_HS    <= '0;
      ChSel_LS    <= '0;
      BUSY        <= CTRL_OFF;
      DONE        <= CTRL_OFF;
      rest_l      <= '0;
      ext_l       <= '0;
      ph1_l       <= '0;
      ipd_l       <= '0;
      ph2_l       <= '0;
      mag_cfg_l   <= '0;
      ramp_l      <= 1'b0;
      sweep_l     <= 1'b0;
      cat_first_l <= 1'b0;
      ano_l       <= '0;
      n_pulses_l  <= '0;
      cat_q       <= '0;
      pulse_cnt   <= '0;
      stop_req    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (STOP && (state_q != IDLE)) begin
        stop_req <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          stop_req <= 1'b0;
          if (START) begin
            rest_l      <= REST_CYC;
            ext_l       <= EXT_CYC;
            ph1_l       <= PH1_CYC;
            ipd_l       <= IPD_CYC;
            ph2_l       <= PH2_CYC;
            mag_cfg_l   <= MAG_CFG;
            ramp_l      <= RAMP;
            sweep_l     <= SWEEP;
            cat_first_l <= CAT_FIRST;
            ano_l       <= CH_ANO;
            n_pulses_l  <= N_PULSES;
            MAG_ST      <= RAMP ? '0 : MAG_CFG;
            cat_q       <= CH_CAT;
            pulse_cnt   <= '0;
            EN_ST       <= 1'b0;
            ChSel_HS    <= '0;
            ChSel_LS    <= '0;
            BUSY        <= 1'b1;
            state_q     <= REST;
          end
        end
        REST: begin
          // No current flows in REST, so a stop can end the train right away.
          if (stop_now) begin
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            stop_req <= 1'b0;
            state_q  <= IDLE;
          end else if (tmr_exp) begin
            EN_ST   <= 1'b1;
            state_q <= LEAD;
          end
        end
        LEAD: begin
          if (tmr_exp) begin
            ChSel_HS <= ph1_hs;
            ChSel_LS <= ph1_ls;
            state_q  <= PH1;
          end
        end
        PH1: begin
          if (tmr_exp) begin
            ChSel_HS <= '0;
            ChSel_LS <= '0;
            state_q  <= IPD;
          end
        end
        IPD: begin
          if (tmr_exp) begin
            ChSel_HS <= ph1_ls;
            ChSel_LS <= ph1_hs;
            state_q  <= PH2;
          end
        end
        PH2: begin
          if (tmr_exp) begin
            ChSel_HS <= '0;
            ChSel_LS <= '0;
            state_q  <= LAG;
          end
        end
        LAG: begin
          if (tmr_exp) begin
            pulse_cnt <= cnt_next;
            MAG_ST    <= mag_next;
            cat_q     <= cat_next;
            EN_ST     <= 1'b0;
            if (last_pulse) begin
              BUSY     <= 1'b0;
              DONE     <= 1'b1;
              stop_req <= 1'b0;
              state_q  <= IDLE;
            end else begin
              state_q  <= REST;
            end
          end
        end
        default: begin
          EN_ST    <= 1'b0;
          ChSel_HS <= '0;
          ChSel_LS <= '0;
          BUSY     <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stim_sequencer_v3.sv
// Testbench for stim_sequencer_v3: expected per-cycle output traces come from a
// pulse-level model of the train (segment lengths, phase polarity, ramp, sweep, stop).
module tb_stim_sequencer_v3;

  localparam int TW    = 16;
  localparam int MAG_W = 5;
  localparam int CH_W  = 4;
  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic             STOP;
  logic [TW-1:0]    REST_CYC, EXT_CYC, PH1_CYC, IPD_CYC, PH2_CYC;
  logic [MAG_W-1:0] MAG_CFG;
  logic             RAMP, SWEEP, CAT_FIRST;
  logic [CH_W-1:0]  CH_ANO, CH_CAT;
  logic [CNT_W-1:0] N_PULSES;
  logic             EN_ST;
  logic [MAG_W-1:0] MAG_ST;
  logic [CH_W-1:0]  ChSel_HS, ChSel_LS;
  logic             BUSY, DONE;

  int vectors     = 0;
  int miscompares = 0;

  typedef logic [15:0] vec_t;

  typedef struct {
    int rest, ext, ph1, ipd, ph2, mag, ano, cat, n;
    bit ramp, sweep, cat_first;
  } cfg_t;

  typedef struct {
    bit en;
    int mag, hs, ls;
    bit busy, done;
  } smp_t;

  smp_t exp_q[$];
  vec_t obs;

  assign obs = {EN_ST, MAG_ST, ChSel_HS, ChSel_LS, BUSY, DONE};

  always #5 CLK = ~CLK;

  stim_sequencer_v3 dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP),
    .REST_CYC(REST_CYC), .EXT_CYC(EXT_CYC), .PH1_CYC(PH1_CYC),
    .IPD_CYC(IPD_CYC), .PH2_CYC(PH2_CYC), .MAG_CFG(MAG_CFG),
    .RAMP(RAMP), .SWEEP(SWEEP), .CAT_FIRST(CAT_FIRST),
    .CH_ANO(CH_ANO), .CH_CAT(CH_CAT), .N_PULSES(N_PULSES),
    .EN_ST(EN_ST), .MAG_ST(MAG_ST), .ChSel_HS(ChSel_HS), .ChSel_LS(ChSel_LS),
    .BUSY(BUSY), .DONE(DONE)
  );

  function automatic vec_t pack(input smp_t s);
    return {s.en, MAG_W'(s.mag), CH_W'(s.hs), CH_W'(s.ls), s.busy, s.done};
  endfunction

  function automatic int cycles(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int sweep_next(input int c, input int ano);
    int n;
    n = c + 1;
    if (n > 8) n = 2;
    if (n == ano) begin
      n = n + 1;
      if (n > 8) n = 2;
    end
    return n;
  endfunction

  task automatic push(input bit en, input int mag, input int hs, input int ls,
                      input bit busy, input bit done);
    smp_t s;
    s.en = en; s.mag = mag; s.hs = hs; s.ls = ls; s.busy = busy; s.done = done;
    exp_q.push_back(s);
  endtask

  // Expected samples start with the first cycle after the START edge; STOP is seen at the edge after sample stop_idx.
  task automatic build_trace(input cfg_t c, input int stop_idx);
    int mag, cat, pulses;
    bit stopped, fin;
    int seg_len[5], seg_hs[5], seg_ls[5];
    exp_q.delete();
    mag = c.ramp ? 0 : c.mag;
    cat = c.cat;
    pulses = 0;
    fin = 0;
    while (!fin) begin
      stopped = 0;
      for (int r = 0; r < cycles(c.rest) && !stopped; r++) begin
        push(1'b0, mag, 0, 0, 1'b1, 1'b0);
        if (exp_q.size() - 1 == stop_idx) stopped = 1;
      end
      if (stopped) begin
        fin = 1;
      end else begin
        seg_len[0] = c.ext; seg_hs[0] = 0; seg_ls[0] = 0;
        seg_len[1] = c.ph1; seg_hs[1] = c.cat_first ? cat : c.ano; seg_ls[1] = c.cat_first ? c.ano : cat;
        seg_len[2] = c.ipd; seg_hs[2] = 0; seg_ls[2] = 0;
        seg_len[3] = c.ph2; seg_hs[3] = seg_ls[1]; seg_ls[3] = seg_hs[1];
        seg_len[4] = c.ext; seg_hs[4] = 0; seg_ls[4] = 0;
        for (int s = 0; s < 5; s++) begin
          for (int k = 0; k < cycles(seg_len[s]); k++) begin
            push(1'b1, mag, seg_hs[s], seg_ls[s], 1'b1, 1'b0);
            if (exp_q.size() - 1 == stop_idx) stopped = 1;
          end
        end
        pulses++;
        if (c.ramp && mag < c.mag) mag++;
        if (c.sweep) cat = sweep_next(cat, c.ano);
        if (stopped || (c.n != 0 && pulses == c.n) || exp_q.size() > 5000) fin = 1;
      end
    end
    push(1'b0, mag, 0, 0, 1'b0, 1'b1);
  endtask

  function automatic cfg_t default_cfg();
    cfg_t c;
    c.rest = 5; c.ext = 2; c.ph1 = 4; c.ipd = 1; c.ph2 = 4;
    c.mag = 31; c.ano = 1; c.cat = 2; c.n = 2;
    c.ramp = 0; c.sweep = 0; c.cat_first = 0;
    return c;
  endfunction

  // Drives one START with the given config, then scrambles the config inputs to show they are latched.
  task automatic applyStimulus(input cfg_t c);
    REST_CYC = TW'(c.rest); EXT_CYC = TW'(c.ext); PH1_CYC = TW'(c.ph1);
    IPD_CYC = TW'(c.ipd); PH2_CYC = TW'(c.ph2); MAG_CFG = MAG_W'(c.mag);
    RAMP = c.ramp; SWEEP = c.sweep; CAT_FIRST = c.cat_first;
    CH_ANO = CH_W'(c.ano); CH_CAT = CH_W'(c.cat); N_PULSES = CNT_W'(c.n);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    REST_CYC = TW'($urandom); EXT_CYC = TW'($urandom); PH1_CYC = TW'($urandom);
    IPD_CYC = TW'($urandom); PH2_CYC = TW'($urandom); MAG_CFG = MAG_W'($urandom);
    RAMP = 1'($urandom); SWEEP = 1'($urandom); CAT_FIRST = 1'($urandom);
    CH_ANO = CH_W'($urandom); CH_CAT = CH_W'($urandom); N_PULSES = CNT_W'($urandom);
  endtask

  task automatic advance(input int j, input int stop_idx, input int start_idx);
    if (j == stop_idx) STOP = 1'b1;
    if (j == start_idx && j < exp_q.size() - 1) START = 1'b1;
    @(posedge CLK); #1;
    STOP = 1'b0;
    START = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    vectors++; if (EN_ST !== 1'b0) begin miscompares++; $display("[TB] FAIL reset EN_ST: got %b want 0", EN_ST); end
    vectors++; if (MAG_ST !== '0) begin miscompares++; $display("[TB] FAIL reset MAG_ST: got %0d want 0", MAG_ST); end
    vectors++; if (ChSel_HS !== '0) begin miscompares++; $display("[TB] FAIL reset ChSel_HS: got %0d want 0", ChSel_HS); end
    vectors++; if (ChSel_LS !== '0) begin miscompares++; $display("[TB] FAIL reset ChSel_LS: got %0d want 0", ChSel_LS); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL reset BUSY: got %b want 0", BUSY); end
    vectors++; if (DONE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset DONE: got %b want 0", DONE); end
  endtask

  task automatic test_train(input string name, input cfg_t c, input int stop_idx, input int start_idx);
    smp_t last;
    build_trace(c, stop_idx);
    applyStimulus(c);
    for (int j = 0; j < exp_q.size(); j++) begin
      vectors++;
      if (obs !== pack(exp_q[j])) begin
        miscompares++;
        $display("[TB] FAIL %s cycle %0d: got {en,mag,hs,ls,busy,done}=%h want %h", name, j, obs, pack(exp_q[j]));
      end
      advance(j, stop_idx, start_idx);
    end
    last = exp_q[$];
    last.done = 1'b0;
    vectors++;
    if (obs !== pack(last)) begin
      miscompares++;
      $display("[TB] FAIL %s idle-after-done: got %h want %h", name, obs, pack(last));
    end
  endtask

  task automatic test_reset_mid_ph2();
    cfg_t c;
    c = default_cfg();
    applyStimulus(c);
    repeat (13) @(posedge CLK);
    #1;
    vectors++;
    if (ChSel_HS !== 4'd2 || ChSel_LS !== 4'd1 || EN_ST !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_ph2 pre: got hs=%0d ls=%0d en=%b want 2 1 1", ChSel_HS, ChSel_LS, EN_ST);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    vectors++;
    if (obs !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_ph2 post: got %h want 0000", obs);
    end
    @(posedge CLK); #1;
    vectors++;
    if (BUSY !== 1'b0 || EN_ST !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_ph2 hold: got busy=%b en=%b want 0 0", BUSY, EN_ST);
    end
  endtask

  task automatic test_random(input int runs);
    cfg_t c;
    int stop_idx;
    for (int r = 0; r < runs; r++) begin
      c.rest = $urandom_range(0, 3); c.ext = $urandom_range(0, 3);
      c.ph1 = $urandom_range(0, 3); c.ipd = $urandom_range(0, 3); c.ph2 = $urandom_range(0, 3);
      c.mag = $urandom_range(0, 31); c.ano = $urandom_range(0, 15); c.cat = $urandom_range(0, 15);
      c.n = $urandom_range(0, 5);
      c.ramp = 1'($urandom); c.sweep = 1'($urandom); c.cat_first = 1'($urandom);
      stop_idx = (c.n == 0) ? $urandom_range(0, 40) : $urandom_range(0, 80);
      test_train("random", c, stop_idx, $urandom_range(0, 20));
    end
  endtask

  initial begin
    cfg_t c;
    RST = 1'b1; START = 1'b0; STOP = 1'b0;
    c = default_cfg();
    REST_CYC = '0; EXT_CYC = '0; PH1_CYC = '0; IPD_CYC = '0; PH2_CYC = '0;
    MAG_CFG = '0; RAMP = 0; SWEEP = 0; CAT_FIRST = 0; CH_ANO = '0; CH_CAT = '0; N_PULSES = '0;

    test_reset();
    test_train("defaults", c, -1, 9);
    c.cat_first = 1;
    test_train("cat_first", c, -1, -1);
    c = default_cfg(); c.ramp = 1; c.mag = 3; c.n = 6;
    test_train("ramp", c, -1, -1);
    c = default_cfg(); c.sweep = 1; c.ano = 3; c.cat = 2; c.n = 8;
    test_train("sweep", c, -1, -1);
    c = default_cfg(); c.n = 0;
    test_train("stop_mid_ph1", c, 8, -1);
    test_train("stop_in_rest", c, 20, -1);
    test_reset_mid_ph2();
    c = default_cfg(); c.rest = 0; c.ext = 0; c.ph1 = 0; c.ipd = 0; c.ph2 = 0;
    test_train("zero_durations", c, -1, -1);
    c = default_cfg(); c.n = 3;
    test_train("stop_at_last_lag", c, 17 + 18 + 18, -1);
    test_random(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stim_sequencer_v3.md
Name: stim_sequencer_v3

Overview:
Clocked, synthesizable successor to the behavioural stimulus generator. It produces charge-balanced biphasic pulse trains on the stimulator's EN_ST, MAG_ST, ChSel_HS and ChSel_LS controls, with all timing counted in CLK cycles. Configuration is latched at start; it adds selectable phase order, magnitude ramping with saturation, cathode channel sweeping with wrap, and a pulse-count limit. Sits between the register file and the HS/LS switch driver of the stimulator front end.

Parameters:
TW, 16, width of every duration field, in cycles
MAG_W, 5, magnitude width
CH_W, 4, channel-select code width
CNT_W, 8, pulse-count width; 0 on N_PULSES means run until stopped
SWEEP_MIN, 4'd2, lowest cathode code in sweep
SWEEP_MAX, 4'd8, highest cathode code in sweep

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
START  in  1  1-cycle pulse; accepted only in IDLE
STOP  in  1  level/pulse; requests graceful stop at end of current pulse
REST_CYC  in  TW  inter-pulse rest duration
EXT_CYC  in  TW  EN lead/lag extension around phases
PH1_CYC  in  TW  first-phase width
IPD_CYC  in  TW  interphase delay
PH2_CYC  in  TW  second-phase width
MAG_CFG  in  MAG_W  fixed magnitude, or ramp ceiling when RAMP=1
RAMP  in  1  ramp magnitude from 0 by +1 per pulse
SWEEP  in  1  advance cathode code after each pulse
CAT_FIRST  in  1  0: anodic phase first; 1: cathodic first
CH_ANO  in  CH_W  anode channel code
CH_CAT  in  CH_W  initial cathode channel code
N_PULSES  in  CNT_W  pulse count limit
EN_ST  out  1  stimulator enable
MAG_ST  out  MAG_W  current magnitude
ChSel_HS  out  CH_W  high-side channel select
ChSel_LS  out  CH_W  low-side channel select
BUSY  out  1  high in any state except IDLE
DONE  out  1  1-cycle pulse on return to IDLE

Behaviour:
- Reset (RST sampled high at posedge): state IDLE, EN_ST=0, MAG_ST=0, ChSel_HS=ChSel_LS=0, BUSY=0, DONE=0, counters cleared. Reset overrides everything, including mid-pulse; outputs go to 0 on the next edge.
- All outputs are registered. States: IDLE -> REST -> LEAD -> PH1 -> IPD -> PH2 -> LAG -> (REST | IDLE).
- Each timed state lasts max(D,1) cycles, where D is its latched duration; a down-counter loads D-1 on entry.
- START in IDLE: latch every config input. Load MAG_ST=0 if RAMP else MAG_CFG, cathode register = CH_CAT, pulse counter = 0; enter REST next cycle. START outside IDLE is ignored.
- REST: EN_ST=0, selects 0. LEAD/IPD/LAG: EN_ST=1, selects 0.
- Polarity: P = anode code, Q = cathode register. Anodic phase drives HS=P, LS=Q; cathodic phase drives HS=Q, LS=P. PH1 is anodic when CAT_FIRST=0, else cathodic; PH2 is the opposite phase.
- On LAG exit (end of pulse): increment the pulse counter.
  - If RAMP and MAG_ST<MAG_CFG: MAG_ST+1. MAG_ST saturates at MAG_CFG; no wrap.
  - If SWEEP: cathode +1; above SWEEP_MAX it wraps to SWEEP_MIN. Any value equal to the anode code is skipped (one further step, same wrap rule).
- End condition at LAG exit: stop_req set, or N_PULSES!=0 and count==N_PULSES. Either gives IDLE with DONE=1 for 1 cycle; otherwise REST.
- STOP sets a sticky stop_req, cleared in IDLE. A pulse in progress is always completed for charge balance. STOP in REST goes to IDLE immediately, with DONE. STOP in IDLE has no effect.
- STOP and end-of-count in the same cycle: a single DONE.
- Config changes while BUSY are ignored until the next START.

Decomposition:
- Package stim_pkg: state enum (IDLE, REST, LEAD, PH1, IPD, PH2, LAG) and the reset/zero constants.
- One sub-module, stim_dur_timer: loadable down-counter of width TW with an expire flag, reused by every timed state.

Test Plan:
- Defaults REST=5, EXT=2, PH1=4, IPD=1, PH2=4, MAG_CFG=31, ANO=1, CAT=2, CAT_FIRST=0, N_PULSES=2 -> EN_ST high 13 cycles per pulse; HS=1/LS=2 for 4 cycles, then HS=2/LS=1 for 4 cycles; exactly 2 pulses; DONE 1 cycle.
- CAT_FIRST=1, same config -> PH1 HS=2/LS=1, PH2 HS=1/LS=2.
- RAMP=1, MAG_CFG=3, N_PULSES=6 -> MAG_ST per pulse 0,1,2,3,3,3.
- SWEEP=1, ANO=3, CAT=2, N_PULSES=8 -> cathode sequence 2,4,5,6,7,8,2,4 (3 skipped, wrap after 8).
- STOP asserted mid-PH1 -> PH2 and LAG complete, then IDLE and DONE. STOP during REST -> IDLE next cycle.
- RST asserted mid-PH2 -> all outputs 0 next edge, BUSY=0; all durations 0 -> each state lasts 1 cycle.
